// File: rtl/vx_uop_ibuffer_pkg.sv
// Shared types and helpers for the per-slot instruction buffer and its MMUL micro-op expander.
package vx_uop_ibuffer_pkg;

  localparam int NW_BITS     = 3;
  localparam int ISW_BITS    = 2;
  localparam int ISSUE_WIDTH = 4;
  localparam int NR_BITS     = 6;
  localparam int UUID_BITS   = 8;
  localparam int NUM_THREADS = 4;

  localparam logic [1:0] EX_ALU        = 2'd0;
  localparam logic [3:0] INST_ALU_MMUL = 4'hE;
  localparam logic [2:0] MMUL_MOD_ACC  = 3'b010;
  localparam logic [2:0] MMUL_MOD_WB   = 3'b000;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } uop_state_e;

  typedef struct packed {
    logic [NW_BITS-1:0]     wid;
    logic [UUID_BITS-1:0]   uuid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            PC;
    logic [1:0]             ex_type;
    logic [3:0]             op_type;
    logic [2:0]             op_mod;
    logic                   wb;
    logic [NR_BITS-1:0]     rd;
    logic [NR_BITS-1:0]     rs1;
    logic [NR_BITS-1:0]     rs2;
    logic [NR_BITS-1:0]     rs3;
    logic [31:0]            imm;
  } ibuf_data_t;

  function automatic logic [ISW_BITS-1:0] wid_to_isw(input logic [NW_BITS-1:0] wid);
    return wid[ISW_BITS-1:0];
  endfunction

  function automatic logic [NW_BITS-ISW_BITS-1:0] wid_to_wis(input logic [NW_BITS-1:0] wid);
    return wid[NW_BITS-1:ISW_BITS];
  endfunction

endpackage

// File: rtl/vx_uop_ibuffer_seq.sv
// Per-slot micro-op sequencer: passes ordinary instructions through and expands a fused
// MMUL into MMUL_STEPS accumulate uops plus one writeback uop, advancing only on slot readiness.
module vx_uop_sequencer
  import vx_uop_ibuffer_pkg::*;
#(
  parameter int MMUL_STEPS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  ibuf_data_t i_data,
  input  logic       i_fifo_ready,
  output logic       o_push,
  output ibuf_data_t o_data,
  output logic       o_done
);

  uop_state_e         r_state;
  logic [2:0]         r_cnt;
  logic               w_mmul_seq;
  logic               w_last;
  logic [2:0]         w_k;
  logic [NR_BITS-1:0] w_k_nr;
  logic [NR_BITS-1:0] w_steps_nr;

  assign w_mmul_seq = (r_state == EXPAND) ||
                      ((i_data.ex_type == EX_ALU) && (i_data.op_type == INST_ALU_MMUL));
  assign w_k        = (r_state == EXPAND) ? r_cnt : 3'd0;
  assign w_k_nr     = NR_BITS'(w_k);
  assign w_steps_nr = NR_BITS'(MMUL_STEPS);
  assign w_last     = !w_mmul_seq || (w_k == 3'(MMUL_STEPS));
  assign o_done     = o_push & w_last;

  // Push qualification: once expanding, decode is held stalled so only slot space matters
  always_comb begin
    o_push = 1'b0;
    if (r_state == EXPAND) begin
      o_push = i_fifo_ready;
    end else begin
      o_push = i_valid & i_fifo_ready;
    end
  end

  // Uop field generation; register index sums wrap at NR_BITS
  always_comb begin
    o_data = i_data;
    if (w_mmul_seq) begin
      if (w_last) begin
        o_data.op_mod = MMUL_MOD_WB;
        o_data.rs1    = i_data.rd;
        o_data.rs2    = i_data.rd + NR_BITS'(1'b1);
      end else begin
        o_data.op_mod = MMUL_MOD_ACC;
        o_data.rd     = i_data.rd + w_k_nr;
        o_data.rs1    = i_data.rs1 + w_k_nr;
        o_data.rs2    = i_data.rs1 + w_k_nr + w_steps_nr;
      end
    end else begin
      o_data = i_data;
    end
  end

  // Sequencer state and uop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (o_push && w_mmul_seq && !w_last) begin
            r_state <= EXPAND;
            r_cnt   <= 3'd1;
          end else begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
          end
        end
        EXPAND: begin
          if (o_push && w_last) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
          end else if (o_push) begin
            r_cnt <= r_cnt + 3'd1;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/vx_uop_ibuffer.sv
// Per-issue-slot instruction buffer with MMUL micro-op expansion; one elastic FIFO per slot.
// Optional IBUF_PERF_EN adds perf_uops / perf_stalls counters.
module vx_uop_ibuffer
  import vx_uop_ibuffer_pkg::*;
#(
  parameter int IBUF_SIZE  = 4,
  parameter int MMUL_STEPS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         decode_valid,
  input  ibuf_data_t                   decode_data,
  output logic                         decode_ready,
  output logic [ISSUE_WIDTH-1:0]       ibuf_valid,
  output ibuf_data_t [ISSUE_WIDTH-1:0] ibuf_data,
  input  logic [ISSUE_WIDTH-1:0]       ibuf_ready,
  output logic [ISSUE_WIDTH-1:0]       ibuf_pop
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0]                  perf_uops,
  output logic [31:0]                  perf_stalls
`endif
);

  localparam int PW = (IBUF_SIZE > 1) ? $clog2(IBUF_SIZE) : 1;
  localparam int CW = $clog2(IBUF_SIZE + 1);

  logic [ISW_BITS-1:0]    w_isw;
  logic [ISSUE_WIDTH-1:0] w_push;
  logic [ISSUE_WIDTH-1:0] w_done;
  logic [ISSUE_WIDTH-1:0] w_fifo_ready;
  ibuf_data_t             w_push_data [ISSUE_WIDTH];

  assign w_isw        = wid_to_isw(decode_data.wid);
  assign decode_ready = |w_done;

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot
    ibuf_data_t    r_mem [IBUF_SIZE];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_sel;
    logic          w_full;
    ibuf_data_t    w_head;

    assign w_sel           = decode_valid && (w_isw == ISW_BITS'(i));
    assign w_full          = (r_count == CW'(IBUF_SIZE));
    assign ibuf_valid[i]   = (r_count != {CW{1'b0}});
    assign ibuf_pop[i]     = ibuf_valid[i] & ibuf_ready[i];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_fifo_ready[i] = !reset && (!w_full || ibuf_pop[i]);

    vx_uop_sequencer #(
      .MMUL_STEPS (MMUL_STEPS)
    ) u_seq (
      .clk          (clk),
      .reset        (reset),
      .i_valid      (w_sel),
      .i_data       (decode_data),
      .i_fifo_ready (w_fifo_ready[i]),
      .o_push       (w_push[i]),
      .o_data       (w_push_data[i]),
      .o_done       (w_done[i])
    );

    // Head presents the in-slot warp index instead of the global warp id
    always_comb begin
      w_head     = r_mem[r_rptr];
      w_head.wid = NW_BITS'(wid_to_wis(w_head.wid));
    end
    assign ibuf_data[i] = w_head;

    // FIFO storage write port
    always_ff @(posedge clk) begin
      if (w_push[i]) begin
        r_mem[r_wptr] <= w_push_data[i];
      end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wptr  <= {PW{1'b0}};
        r_rptr  <= {PW{1'b0}};
        r_count <= {CW{1'b0}};
      end else begin
        if (w_push[i]) begin
          r_wptr <= (r_wptr == PW'(IBUF_SIZE - 1)) ? {PW{1'b0}} : r_wptr + PW'(1'b1);
        end
        if (ibuf_pop[i]) begin
          r_rptr <= (r_rptr == PW'(IBUF_SIZE - 1)) ? {PW{1'b0}} : r_rptr + PW'(1'b1);
        end
        case ({w_push[i], ibuf_pop[i]})
          2'b10:   r_count <= r_count + CW'(1'b1);
          2'b01:   r_count <= r_count - CW'(1'b1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef IBUF_PERF_EN
  logic [31:0] r_perf_uops;
  logic [31:0] r_perf_stalls;

  // At most one slot pushes per cycle since decode targets a single slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_uops   <= 32'd0;
      r_perf_stalls <= 32'd0;
    end else begin
      if (|w_push) begin
        r_perf_uops <= r_perf_uops + 32'd1;
      end
      if (decode_valid && !decode_ready) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_uops   = r_perf_uops;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_vx_uop_ibuffer.sv
// Directed self-checking bench for vx_uop_ibuffer (IBUF_SIZE=4, MMUL_STEPS=2).
module tb_vx_uop_ibuffer;
  import vx_uop_ibuffer_pkg::*;

  localparam logic [3:0] INST_ALU_ADD = 4'h0;

  logic                         clk;
  logic                         reset;
  logic                         decode_valid;
  ibuf_data_t                   decode_data;
  logic                         decode_ready;
  logic [ISSUE_WIDTH-1:0]       ibuf_valid;
  ibuf_data_t [ISSUE_WIDTH-1:0] ibuf_data;
  logic [ISSUE_WIDTH-1:0]       ibuf_ready;
  logic [ISSUE_WIDTH-1:0]       ibuf_pop;

  int n_chk;
  int n_err;

  vx_uop_ibuffer #(
    .IBUF_SIZE  (4),
    .MMUL_STEPS (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .decode_valid (decode_valid),
    .decode_data  (decode_data),
    .decode_ready (decode_ready),
    .ibuf_valid   (ibuf_valid),
    .ibuf_data    (ibuf_data),
    .ibuf_ready   (ibuf_ready),
    .ibuf_pop     (ibuf_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ibuf_data_t mk(input logic [2:0] wid, input logic [3:0] op,
                                    input logic [5:0] rd, input logic [5:0] rs1,
                                    input logic [5:0] rs2);
    ibuf_data_t d;
    d.wid     = wid;
    d.uuid    = 8'h5A;
    d.tmask   = 4'hF;
    d.PC      = 32'h1000_0040;
    d.ex_type = EX_ALU;
    d.op_type = op;
    d.op_mod  = 3'd0;
    d.wb      = 1'b1;
    d.rd      = rd;
    d.rs1     = rs1;
    d.rs2     = rs2;
    d.rs3     = 6'd33;
    d.imm     = 32'h0000_0ABC;
    return d;
  endfunction

  // Check the head of slot s, then let one clock edge pass (caller controls ibuf_ready)
  task automatic pop_check(input int s, input logic [5:0] rd, input logic [5:0] rs1,
                           input logic [5:0] rs2, input logic [2:0] md, input string tag);
    ibuf_data_t h;
    h = ibuf_data[s];
    chk({tag, ".valid"}, 128'(ibuf_valid[s]), 128'(1'b1));
    chk({tag, ".rd"},    128'(h.rd),     128'(rd));
    chk({tag, ".rs1"},   128'(h.rs1),    128'(rs1));
    chk({tag, ".rs2"},   128'(h.rs2),    128'(rs2));
    chk({tag, ".mod"},   128'(h.op_mod), 128'(md));
    tick();
  endtask

  initial begin
    ibuf_data_t exp_d;
    ibuf_data_t h;
    n_chk        = 0;
    n_err        = 0;
    reset        = 1'b1;
    decode_valid = 1'b0;
    decode_data  = mk(3'd0, INST_ALU_ADD, 6'd0, 6'd0, 6'd0);
    ibuf_ready   = 4'b0000;
    repeat (2) tick();

    // Reset: nothing valid and decode never accepted even with a valid request
    decode_valid = 1'b1;
    decode_data  = mk(3'd5, INST_ALU_ADD, 6'd7, 6'd2, 6'd3);
    #1;
    chk("rst.ibuf_valid",   128'(ibuf_valid),   128'(4'b0000));
    chk("rst.decode_ready", 128'(decode_ready), 128'(1'b0));
    tick();
    reset        = 1'b0;
    decode_valid = 1'b0;
    tick();

    // 1: ADD wid5 -> slot1, wis1; accepted same cycle, head visible next cycle
    ibuf_ready   = 4'b1111;
    decode_valid = 1'b1;
    decode_data  = mk(3'd5, INST_ALU_ADD, 6'd7, 6'd2, 6'd3);
    #1;
    chk("t1.decode_ready", 128'(decode_ready), 128'(1'b1));
    tick();
    decode_valid = 1'b0;
    #1;
    exp_d     = mk(3'd5, INST_ALU_ADD, 6'd7, 6'd2, 6'd3);
    exp_d.wid = 3'd1;
    chk("t1.ibuf_valid", 128'(ibuf_valid), 128'(4'b0010));
    chk("t1.data",       128'(ibuf_data[1]), 128'(exp_d));
    chk("t1.pop",        128'(ibuf_pop), 128'(4'b0010));
    tick();
    chk("t1.drained",    128'(ibuf_valid), 128'(4'b0000));

    // 2: MMUL rd8 rs1 4 -> (8,4,6,2),(9,5,7,2),(8,8,9,0); decode_ready only with the final push
    ibuf_ready   = 4'b0000;
    decode_valid = 1'b1;
    decode_data  = mk(3'd0, INST_ALU_MMUL, 6'd8, 6'd4, 6'd0);
    #1;
    chk("t2.dr_uop0", 128'(decode_ready), 128'(1'b0));
    tick();
    #1;
    chk("t2.dr_uop1", 128'(decode_ready), 128'(1'b0));
    chk("t2.valid0",  128'(ibuf_valid), 128'(4'b0001));
    tick();
    #1;
    chk("t2.dr_uop2", 128'(decode_ready), 128'(1'b1));
    tick();
    decode_valid = 1'b0;
    ibuf_ready   = 4'b0001;
    #1;
    pop_check(0, 6'd8, 6'd4, 6'd6, 3'd2, "t2.u0");
    pop_check(0, 6'd9, 6'd5, 6'd7, 3'd2, "t2.u1");
    h = ibuf_data[0];
    chk("t2.u2.rs3", 128'(h.rs3), 128'(6'd33));
    chk("t2.u2.pc",  128'(h.PC),  128'(32'h1000_0040));
    chk("t2.u2.imm", 128'(h.imm), 128'(32'h0000_0ABC));
    chk("t2.u2.wid", 128'(h.wid), 128'(3'd0));
    pop_check(0, 6'd8, 6'd8, 6'd9, 3'd0, "t2.u2");
    ibuf_ready = 4'b0000;
    chk("t2.drained", 128'(ibuf_valid), 128'(4'b0000));

    // 3: fill slot0, then MMUL to slot2 expands in 3 cycles regardless
    decode_valid = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      decode_data = mk(3'd0, INST_ALU_ADD, 6'(r), 6'd0, 6'd0);
      tick();
    end
    decode_data = mk(3'd0, INST_ALU_ADD, 6'd5, 6'd0, 6'd0);
    #1;
    chk("t3.full_stall", 128'(decode_ready), 128'(1'b0));
    decode_data = mk(3'd2, INST_ALU_MMUL, 6'd10, 6'd20, 6'd0);
    #1;
    chk("t3.dr_uop0", 128'(decode_ready), 128'(1'b0));
    tick();
    tick();
    #1;
    chk("t3.dr_uop2", 128'(decode_ready), 128'(1'b1));
    tick();
    decode_valid = 1'b0;
    #1;
    chk("t3.valid", 128'(ibuf_valid), 128'(4'b0101));
    h = ibuf_data[0];
    chk("t3.slot0_head", 128'(h.rd), 128'(6'd1));
    // Push into a full slot while its head pops
    decode_valid = 1'b1;
    decode_data  = mk(3'd0, INST_ALU_ADD, 6'd5, 6'd0, 6'd0);
    ibuf_ready   = 4'b0001;
    #1;
    chk("t3.full_pop_push", 128'(decode_ready), 128'(1'b1));
    tick();
    decode_valid = 1'b0;
    ibuf_ready   = 4'b0100;
    #1;
    pop_check(2, 6'd10, 6'd20, 6'd22, 3'd2, "t3.u0");
    pop_check(2, 6'd11, 6'd21, 6'd23, 3'd2, "t3.u1");
    pop_check(2, 6'd10, 6'd10, 6'd11, 3'd0, "t3.u2");
    ibuf_ready = 4'b0001;
    for (int r = 2; r <= 5; r++) begin
      pop_check(0, 6'(r), 6'd0, 6'd0, 3'd0, "t3.slot0");
    end
    ibuf_ready = 4'b0000;
    chk("t3.drained", 128'(ibuf_valid), 128'(4'b0000));

    // 4: slot3 fills after uop1; sequencer holds, then resumes with uop2
    decode_valid = 1'b1;
    decode_data  = mk(3'd3, INST_ALU_ADD, 6'd30, 6'd0, 6'd0);
    tick();
    decode_data  = mk(3'd3, INST_ALU_ADD, 6'd31, 6'd0, 6'd0);
    tick();
    decode_data  = mk(3'd3, INST_ALU_MMUL, 6'd8, 6'd4, 6'd0);
    tick();
    tick();
    #1;
    chk("t4.hold0", 128'(decode_ready), 128'(1'b0));
    tick();
    #1;
    chk("t4.hold1", 128'(decode_ready), 128'(1'b0));
    chk("t4.valid", 128'(ibuf_valid), 128'(4'b1000));
    ibuf_ready = 4'b1000;
    #1;
    chk("t4.release", 128'(decode_ready), 128'(1'b1));
    tick();
    decode_valid = 1'b0;
    #1;
    pop_check(3, 6'd31, 6'd0, 6'd0, 3'd0, "t4.add");
    pop_check(3, 6'd8,  6'd4, 6'd6, 3'd2, "t4.u0");
    pop_check(3, 6'd9,  6'd5, 6'd7, 3'd2, "t4.u1");
    pop_check(3, 6'd8,  6'd8, 6'd9, 3'd0, "t4.u2");
    ibuf_ready = 4'b0000;
    chk("t4.drained", 128'(ibuf_valid), 128'(4'b0000));

    // 5: register index wrap, rd=63 rs1=62
    decode_valid = 1'b1;
    decode_data  = mk(3'd1, INST_ALU_MMUL, 6'd63, 6'd62, 6'd0);
    repeat (3) tick();
    decode_valid = 1'b0;
    ibuf_ready   = 4'b0010;
    #1;
    pop_check(1, 6'd63, 6'd62, 6'd0, 3'd2, "t5.u0");
    pop_check(1, 6'd0,  6'd63, 6'd1, 3'd2, "t5.u1");
    pop_check(1, 6'd63, 6'd63, 6'd0, 3'd0, "t5.u2");
    ibuf_ready = 4'b0000;

    // 6: reset after uop0 drops the partial sequence; the held MMUL restarts cleanly
    decode_valid = 1'b1;
    decode_data  = mk(3'd0, INST_ALU_MMUL, 6'd8, 6'd4, 6'd0);
    tick();
    #1;
    chk("t6.pre", 128'(ibuf_valid), 128'(4'b0001));
    reset = 1'b1;
    #1;
    chk("t6.rst_valid", 128'(ibuf_valid),   128'(4'b0000));
    chk("t6.rst_dready", 128'(decode_ready), 128'(1'b0));
    tick();
    reset = 1'b0;
    tick();
    tick();
    #1;
    chk("t6.dr_uop2", 128'(decode_ready), 128'(1'b1));
    tick();
    decode_valid = 1'b0;
    ibuf_ready   = 4'b0001;
    #1;
    pop_check(0, 6'd8, 6'd4, 6'd6, 3'd2, "t6.u0");
    pop_check(0, 6'd9, 6'd5, 6'd7, 3'd2, "t6.u1");
    pop_check(0, 6'd8, 6'd8, 6'd9, 3'd0, "t6.u2");
    chk("t6.drained", 128'(ibuf_valid), 128'(4'b0000));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
